// File: rtl/exec_pkg.sv
// Shared types for the execution sequencer of the accumulator CPU.
package exec_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } exec_state_t;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        USER      = 2'd1,
        BREAK     = 2'd2,
        STEP_DONE = 2'd3
    } halt_cause_t;

endpackage

// File: rtl/exec_ctrl_if.sv
// Control/status bundle between the debug host, the pc and exec_ctrl.
interface exec_ctrl_if
    import exec_pkg::*;
#(
    parameter int IP_W   = 8,
    parameter int STEP_W = 8,
    parameter int CNT_W  = 16
);
    logic              run_req;
    logic              halt_req;
    logic              step_req;
    logic [STEP_W-1:0] step_cnt;
    logic              bp_en;
    logic [IP_W-1:0]   bp_addr;
    logic [IP_W-1:0]   ip;
    logic              clr_cnt;
    logic              cpu_en;
    exec_state_t       state;
    halt_cause_t       halt_cause;
    logic [CNT_W-1:0]  instr_cnt;

    modport master (
        output run_req, halt_req, step_req, step_cnt,
        output bp_en, bp_addr, ip, clr_cnt,
        input  cpu_en, state, halt_cause, instr_cnt
    );

    modport slave (
        input  run_req, halt_req, step_req, step_cnt,
        input  bp_en, bp_addr, ip, clr_cnt,
        output cpu_en, state, halt_cause, instr_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; clear has priority over count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ce && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/exec_ctrl.sv
// Run/halt/step sequencer with one instruction breakpoint.
// Drives the global datapath enable cpu_en.
module exec_ctrl
    import exec_pkg::*;
#(
    parameter int IP_W         = 8,
    parameter int STEP_W       = 8,
    parameter int CNT_W        = 16,
    parameter bit RUN_ON_RESET = 1'b0
) (
    input logic clk,
    input logic rst_n,
    exec_ctrl_if.slave bus
);
    localparam exec_state_t RST_ST = RUN_ON_RESET ? RUN : HALT;

    exec_state_t       state_q, state_d;
    halt_cause_t       cause_q, cause_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              skip_q, skip_d;
    logic              bp_match;
    logic              en;

    assign bp_match = bus.bp_en && (bus.ip == bus.bp_addr) && !skip_q;
    assign en       = (state_q != HALT) && !bp_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_ST;
            cause_q <= NONE;
            rem_q   <= '0;
            skip_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            rem_q   <= rem_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        rem_d   = rem_q;
        skip_d  = en ? 1'b0 : skip_q;
        unique case (state_q)
            HALT: begin
                // skip_bp lets a resume execute the breakpointed instruction
                if (!bus.halt_req) begin
                    if (bus.run_req) begin
                        state_d = RUN;
                        cause_d = NONE;
                        skip_d  = 1'b1;
                    end else if (bus.step_req && (bus.step_cnt != '0)) begin
                        state_d = STEP;
                        cause_d = NONE;
                        skip_d  = 1'b1;
                        rem_d   = bus.step_cnt;
                    end
                end
            end
            RUN: begin
                if (bp_match) begin
                    state_d = HALT;
                    cause_d = BREAK;
                end else if (bus.halt_req) begin
                    state_d = HALT;
                    cause_d = USER;
                end
            end
            STEP: begin
                if (bp_match) begin
                    state_d = HALT;
                    cause_d = BREAK;
                    rem_d   = '0;
                end else if (bus.halt_req) begin
                    state_d = HALT;
                    cause_d = USER;
                    rem_d   = '0;
                end else if (bus.run_req) begin
                    state_d = RUN;
                    rem_d   = '0;
                end else begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == STEP_W'(1)) begin
                        state_d = HALT;
                        cause_d = STEP_DONE;
                    end
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (en),
        .clr   (bus.clr_cnt),
        .cnt   (bus.instr_cnt)
    );

    assign bus.cpu_en     = en;
    assign bus.state      = state_q;
    assign bus.halt_cause = cause_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: vector table plus breakpoint,
// saturation and mid-run reset sequences.
module tb_exec_ctrl;
    import exec_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] ip = 8'd0;
    logic pc_load = 1'b0;
    logic [7:0] pc_val = 8'd0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    exec_ctrl_if #(.IP_W(8), .STEP_W(8), .CNT_W(16)) bus ();

    exec_ctrl #(
        .IP_W(8), .STEP_W(8), .CNT_W(16), .RUN_ON_RESET(1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // simple pc model: increments on enabled edges, can be loaded (jump)
    always @(posedge clk) begin
        if (pc_load) ip <= pc_val;
        else if (bus.cpu_en) ip <= ip + 8'd1;
    end
    assign bus.ip = ip;

    typedef struct {
        logic        run;
        logic        halt;
        logic        step;
        logic [7:0]  cnt;
        logic        clr;
        logic        en;
        logic [1:0]  st;
        logic [1:0]  cause;
        logic [15:0] ic;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic r, input logic h, input logic s,
        input logic [7:0] c, input logic cl, input logic e,
        input logic [1:0] st, input logic [1:0] ca, input logic [15:0] ic
    );
        vec_t v;
        v.run = r; v.halt = h; v.step = s; v.cnt = c; v.clr = cl;
        v.en = e; v.st = st; v.cause = ca; v.ic = ic;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, a, e);
        end
    endtask

    task automatic chk_out(input string nm, input logic e,
                           input logic [1:0] st, input logic [1:0] ca,
                           input logic [15:0] ic);
        chk({nm, "_en"}, 32'(bus.cpu_en), 32'(e));
        chk({nm, "_st"}, 32'(bus.state), 32'(st));
        chk({nm, "_cause"}, 32'(bus.halt_cause), 32'(ca));
        chk({nm, "_cnt"}, 32'(bus.instr_cnt), 32'(ic));
    endtask

    task automatic clr_in();
        bus.run_req = 0; bus.halt_req = 0; bus.step_req = 0;
        bus.step_cnt = 0; bus.clr_cnt = 0;
    endtask

    logic [7:0] ip_hold;

    initial begin
        clr_in();
        bus.bp_en = 0;
        bus.bp_addr = 8'd0;

        // run/halt/step table, observed before each rising edge
        tv.push_back(mk(0,0,0,0,0, 0,0,0,0));
        tv.push_back(mk(0,0,0,0,0, 0,0,0,0));
        tv.push_back(mk(0,0,0,0,0, 0,0,0,0));
        tv.push_back(mk(1,0,0,0,0, 0,0,0,0));
        for (int k = 0; k < 10; k++)
            tv.push_back(mk(0,0,0,0,0, 1,1,0,16'(k)));
        tv.push_back(mk(1,1,0,0,0, 1,1,0,10));
        tv.push_back(mk(0,0,0,0,0, 0,0,1,11));
        tv.push_back(mk(0,0,1,3,0, 0,0,1,11));
        tv.push_back(mk(0,0,0,0,0, 1,2,0,11));
        tv.push_back(mk(0,0,0,0,0, 1,2,0,12));
        tv.push_back(mk(0,0,0,0,0, 1,2,0,13));
        tv.push_back(mk(0,0,0,0,0, 0,0,3,14));
        tv.push_back(mk(0,0,1,0,0, 0,0,3,14));
        tv.push_back(mk(0,1,0,0,0, 0,0,3,14));
        tv.push_back(mk(0,0,1,2,0, 0,0,3,14));
        tv.push_back(mk(0,0,0,0,0, 1,2,0,14));
        tv.push_back(mk(0,1,0,0,0, 1,2,0,15));
        tv.push_back(mk(0,0,0,0,0, 0,0,1,16));
        tv.push_back(mk(0,0,1,5,0, 0,0,1,16));
        tv.push_back(mk(0,0,0,0,0, 1,2,0,16));
        tv.push_back(mk(1,0,0,0,0, 1,2,0,17));
        tv.push_back(mk(0,0,0,0,0, 1,1,0,18));
        tv.push_back(mk(0,0,1,2,0, 1,1,0,19));
        tv.push_back(mk(0,0,0,0,1, 1,1,0,20));
        tv.push_back(mk(0,1,0,0,0, 1,1,0,0));
        tv.push_back(mk(0,0,0,0,0, 0,0,1,1));

        repeat (2) @(negedge clk);
        #1 chk_out("reset", 0, 0, 0, 0);

        foreach (tv[i]) begin
            @(negedge clk);
            if (i == 0) rst_n = 1;
            bus.run_req  = tv[i].run;
            bus.halt_req = tv[i].halt;
            bus.step_req = tv[i].step;
            bus.step_cnt = tv[i].cnt;
            bus.clr_cnt  = tv[i].clr;
            #1 chk_out($sformatf("vec%0d", i), tv[i].en, tv[i].st,
                       tv[i].cause, tv[i].ic);
        end

        // breakpoint at 0x05, pc starting from 0
        @(negedge clk);
        clr_in();
        bus.clr_cnt = 1; pc_load = 1; pc_val = 8'd0;
        bus.bp_en = 1; bus.bp_addr = 8'h05;
        @(negedge clk);
        bus.clr_cnt = 0; pc_load = 0; bus.run_req = 1;
        #1 chk("bp_start_ip", 32'(ip), 0);
        @(negedge clk);
        bus.run_req = 0;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("bp_run%0d_ip", i), 32'(ip), 32'(i));
            chk($sformatf("bp_run%0d_en", i), 32'(bus.cpu_en), 1);
            @(negedge clk);
        end
        #1 chk("bp_hit_ip", 32'(ip), 5);
        chk("bp_hit_en", 32'(bus.cpu_en), 0);
        @(negedge clk);
        #1 chk_out("bp_halt", 0, 0, 2, 5);
        chk("bp_halt_ip", 32'(ip), 5);
        bus.run_req = 1;
        @(negedge clk);
        bus.run_req = 0;
        #1 chk_out("bp_resume", 1, 1, 0, 5);
        chk("bp_resume_ip", 32'(ip), 5);
        @(negedge clk);
        #1 chk("bp_ip6", 32'(ip), 6);
        chk("bp_ip6_en", 32'(bus.cpu_en), 1);
        @(negedge clk);
        #1 chk("bp_ip7", 32'(ip), 7);
        pc_load = 1; pc_val = 8'd4;
        @(negedge clk);
        pc_load = 0;
        #1 chk("bp_jmp_ip", 32'(ip), 4);
        chk("bp_jmp_en", 32'(bus.cpu_en), 1);
        @(negedge clk);
        #1 chk("bp_rehit_en", 32'(bus.cpu_en), 0);
        @(negedge clk);
        #1 chk_out("bp_rehalt", 0, 0, 2, 9);

        // counter saturation
        bus.bp_en = 0;
        bus.clr_cnt = 1; bus.run_req = 1;
        @(negedge clk);
        clr_in();
        #1 chk_out("sat_start", 1, 1, 0, 0);
        repeat (65534) @(negedge clk);
        #1 chk("sat_fffe", 32'(bus.instr_cnt), 32'hFFFE);
        @(negedge clk);
        #1 chk("sat_ffff", 32'(bus.instr_cnt), 32'hFFFF);
        repeat (5) @(negedge clk);
        #1 chk("sat_hold", 32'(bus.instr_cnt), 32'hFFFF);
        bus.clr_cnt = 1;
        @(negedge clk);
        bus.clr_cnt = 0;
        #1 chk("sat_clr", 32'(bus.instr_cnt), 0);

        // asynchronous reset while running
        ip_hold = ip;
        rst_n = 0;
        #1 chk_out("arst", 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1 chk("arst_ip", 32'(ip), 32'(ip_hold));
        rst_n = 1;
        @(negedge clk);
        #1 chk_out("arst_rel", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
